// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the memop encoding and the FSM state encoding.
package mem_lsu_pkg;

  localparam int MEMOP_LEN = 4;

  localparam logic [MEMOP_LEN-1:0] MEMOP_NONE = 4'b0000;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LB   = 4'b0001;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LH   = 4'b0010;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LW   = 4'b0011;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LD   = 4'b0100;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LBU  = 4'b0101;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LHU  = 4'b0110;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LWU  = 4'b0111;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SB   = 4'b1001;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SH   = 4'b1010;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SW   = 4'b1011;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SD   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: memop decode, store lane shift / byte mask,
// misalignment check and load extraction with sign/zero extension.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [MEMOP_LEN-1:0] i_memop,
  input  logic [2:0]           i_lane,
  input  logic [XLEN-1:0]      i_rs2,
  output logic                 o_valid,
  output logic                 o_store,
  output logic                 o_unsigned,
  output logic [1:0]           o_size,
  output logic                 o_misaligned,
  output logic [XLEN-1:0]      o_wdata,
  output logic [XLEN/8-1:0]    o_wmask,
  input  logic [2:0]           i_ld_lane,
  input  logic [1:0]           i_ld_size,
  input  logic                 i_ld_unsigned,
  input  logic [XLEN-1:0]      i_rdata,
  output logic [XLEN-1:0]      o_ld_data
);

  logic [2:0]      align_mask;
  logic [7:0]      size_ones;
  logic [XLEN-1:0] rd_shift;

  always_comb begin
    o_valid    = 1'b1;
    o_store    = 1'b0;
    o_unsigned = 1'b0;
    o_size     = 2'd0;
    case (i_memop)
      MEMOP_LB:  o_size = 2'd0;
      MEMOP_LH:  o_size = 2'd1;
      MEMOP_LW:  o_size = 2'd2;
      MEMOP_LD:  o_size = 2'd3;
      MEMOP_LBU: begin o_size = 2'd0; o_unsigned = 1'b1; end
      MEMOP_LHU: begin o_size = 2'd1; o_unsigned = 1'b1; end
      MEMOP_LWU: begin o_size = 2'd2; o_unsigned = 1'b1; end
      MEMOP_SB:  begin o_size = 2'd0; o_store = 1'b1; end
      MEMOP_SH:  begin o_size = 2'd1; o_store = 1'b1; end
      MEMOP_SW:  begin o_size = 2'd2; o_store = 1'b1; end
      MEMOP_SD:  begin o_size = 2'd3; o_store = 1'b1; end
      default:   o_valid = 1'b0;
    endcase
  end

  always_comb begin
    case (o_size)
      2'd0:    begin align_mask = 3'b000; size_ones = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_ones = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_ones = 8'h0F; end
      default: begin align_mask = 3'b111; size_ones = 8'hFF; end
    endcase
  end

  assign o_misaligned = o_valid && ((i_lane & align_mask) != 3'b000);
  assign o_wdata      = i_rs2 << {i_lane, 3'b000};
  assign o_wmask      = size_ones << i_lane;

  // Response carries the whole aligned doubleword; bring the lane to bit 0.
  assign rd_shift = i_rdata >> {i_ld_lane, 3'b000};

  always_comb begin
    case (i_ld_size)
      2'd0: o_ld_data = i_ld_unsigned ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                      : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      2'd1: o_ld_data = i_ld_unsigned ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                      : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      2'd2: o_ld_data = i_ld_unsigned ? {{(XLEN-32){1'b0}}, rd_shift[31:0]}
                                      : {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
      default: o_ld_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one valid/ready memory transaction per
// memop, stalls the pipeline while it is outstanding, returns writeback data.
//
// state | meaning
// IDLE  | pass ALU result; on a valid aligned memop latch request, stall
// REQ   | o_req_valid high, fields frozen until i_req_ready
// WAIT  | waiting for i_resp_valid (load data or store ack)
// DONE  | o_done pulse, stall released, latched load data on o_wb_data
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEMOP_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEMOP_LEN-1:0] i_memop,
  input  logic [XLEN-1:0]      i_exc_alu_out,
  input  logic [XLEN-1:0]      i_rs2_data,
  output logic                 o_stall,
  output logic [XLEN-1:0]      o_wb_data,
  output logic                 o_done,
  output logic                 o_misaligned,
  output logic                 o_req_valid,
  input  logic                 i_req_ready,
  output logic [XLEN-1:0]      o_req_addr,
  output logic                 o_req_wen,
  output logic [XLEN-1:0]      o_req_wdata,
  output logic [XLEN/8-1:0]    o_req_wmask,
  input  logic                 i_resp_valid,
  input  logic [XLEN-1:0]      i_resp_rdata
);

  lsu_state_e          state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   wmask_q, wmask_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [XLEN-1:0]     ld_data_q, ld_data_d;

  logic                op_valid, op_store, op_unsigned, op_misaligned;
  logic [1:0]          op_size;
  logic [XLEN-1:0]     op_wdata, ld_data;
  logic [XLEN/8-1:0]   op_wmask;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_memop       (i_memop),
    .i_lane        (i_exc_alu_out[2:0]),
    .i_rs2         (i_rs2_data),
    .o_valid       (op_valid),
    .o_store       (op_store),
    .o_unsigned    (op_unsigned),
    .o_size        (op_size),
    .o_misaligned  (op_misaligned),
    .o_wdata       (op_wdata),
    .o_wmask       (op_wmask),
    .i_ld_lane     (addr_q[2:0]),
    .i_ld_size     (size_q),
    .i_ld_unsigned (uns_q),
    .i_rdata       (i_resp_rdata),
    .o_ld_data     (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    size_d       = size_q;
    uns_d        = uns_q;
    ld_data_d    = ld_data_q;
    o_stall      = 1'b0;
    o_wb_data    = '0;
    o_done       = 1'b0;
    o_misaligned = 1'b0;
    o_req_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_wb_data = i_exc_alu_out;
        if (op_valid) begin
          if (op_misaligned) begin
            o_misaligned = 1'b1;
          end else begin
            o_stall = 1'b1;
            addr_d  = i_exc_alu_out;
            wen_d   = op_store;
            wdata_d = op_wdata;
            wmask_d = op_wmask;
            size_d  = op_size;
            uns_d   = op_unsigned;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        o_stall     = 1'b1;
        o_req_valid = 1'b1;
        if (i_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        o_stall = 1'b1;
        if (i_resp_valid) begin
          ld_data_d = wen_q ? '0 : ld_data;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done    = 1'b1;
        o_wb_data = ld_data_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign o_req_addr  = addr_q;
  assign o_req_wen   = wen_q;
  assign o_req_wdata = wdata_q;
  assign o_req_wmask = wmask_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized memops
// checked cycle by cycle against a behavioural load/store model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_memop;
  logic [63:0] i_exc_alu_out, i_rs2_data, i_resp_rdata;
  logic        i_req_ready, i_resp_valid;
  logic        o_stall, o_done, o_misaligned, o_req_valid, o_req_wen;
  logic [63:0] o_wb_data, o_req_addr, o_req_wdata;
  logic [7:0]  o_req_wmask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(64), .MEMOP_LEN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_memop       (i_memop),
    .i_exc_alu_out (i_exc_alu_out),
    .i_rs2_data    (i_rs2_data),
    .o_stall       (o_stall),
    .o_wb_data     (o_wb_data),
    .o_done        (o_done),
    .o_misaligned  (o_misaligned),
    .o_req_valid   (o_req_valid),
    .i_req_ready   (i_req_ready),
    .o_req_addr    (o_req_addr),
    .o_req_wen     (o_req_wen),
    .o_req_wdata   (o_req_wdata),
    .o_req_wmask   (o_req_wmask),
    .i_resp_valid  (i_resp_valid),
    .i_resp_rdata  (i_resp_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes (0 = not a memory op), store flag, unsigned flag.
  function automatic void decode(input logic [3:0] op, output int nb,
                                 output bit st, output bit uns);
    int o;
    o = int'(op);
    nb = 0; st = 0; uns = 0;
    if (o >= 1 && o <= 4)       nb = 1 << (o - 1);
    else if (o >= 5 && o <= 7)  begin nb = 1 << (o - 5); uns = 1; end
    else if (o >= 9 && o <= 12) begin nb = 1 << (o - 9); st = 1; end
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int lane,
                                             input int nb, input bit uns);
    logic [63:0] v, m;
    v = rdata >> (8 * lane);
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!uns && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  // Called just after a rising edge; that cycle is cycle 0 of the op.
  task automatic run_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rs2,
                        input logic [63:0] rdata, input int rdy_wait, input int resp_wait);
    int nb, lane;
    bit st, uns;
    logic [63:0] exp_wd, exp_wb;
    logic [7:0]  exp_wm;
    decode(op, nb, st, uns);
    lane = int'(addr[2:0]);
    i_memop = op; i_exc_alu_out = addr; i_rs2_data = rs2;
    i_req_ready = 1'b0; i_resp_valid = 1'b0;
    @(negedge clk);
    if (nb == 0) begin
      check("none_wb", o_wb_data, addr);
      check("none_stall", o_stall, 0);
      check("none_req", o_req_valid, 0);
    end else if ((lane % nb) != 0) begin
      check("mis_flag", o_misaligned, 1);
      check("mis_stall", o_stall, 0);
      check("mis_req", o_req_valid, 0);
    end else begin
      check("issue_stall", o_stall, 1);
      check("issue_mis", o_misaligned, 0);
      exp_wd = rs2 << (8 * lane);
      exp_wm = 8'(((1 << nb) - 1) << lane);
      exp_wb = st ? 64'd0 : model_load(rdata, lane, nb, uns);
      for (int k = 0; k <= rdy_wait; k++) begin
        @(posedge clk); #1;
        i_req_ready  = (k == rdy_wait);
        i_resp_valid = 1'($urandom_range(0, 1));
        i_resp_rdata = {$urandom, $urandom};
        @(negedge clk);
        check("req_valid", o_req_valid, 1);
        check("req_addr", o_req_addr, addr);
        check("req_wen", o_req_wen, 64'(st));
        check("req_stall", o_stall, 1);
        check("req_done", o_done, 0);
        if (st) begin
          check("req_wdata", o_req_wdata, exp_wd);
          check("req_wmask", o_req_wmask, exp_wm);
        end
      end
      for (int k = 0; k <= resp_wait; k++) begin
        @(posedge clk); #1;
        i_req_ready  = 1'($urandom_range(0, 1));
        i_resp_valid = (k == resp_wait);
        i_resp_rdata = (k == resp_wait) ? rdata : {$urandom, $urandom};
        @(negedge clk);
        check("wait_req", o_req_valid, 0);
        check("wait_stall", o_stall, 1);
        check("wait_done", o_done, 0);
      end
      @(posedge clk); #1;
      i_req_ready = 1'b0; i_resp_valid = 1'b0; i_resp_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("done_pulse", o_done, 1);
      check("done_stall", o_stall, 0);
      check("done_wb", o_wb_data, exp_wb);
    end
    @(posedge clk); #1;
    i_memop = 4'd0; i_exc_alu_out = 64'd0;
    i_req_ready = 1'b0; i_resp_valid = 1'b0;
    @(negedge clk);
    check("after_done", o_done, 0);
    check("after_stall", o_stall, 0);
    check("after_req", o_req_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, lane;
    bit st, uns;
    logic [3:0]  op;
    logic [63:0] addr;
    rst = 1'b1; i_memop = 4'd0; i_exc_alu_out = 64'd0; i_rs2_data = 64'd0;
    i_req_ready = 1'b0; i_resp_valid = 1'b0; i_resp_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", o_stall, 0);
    check("rst_done", o_done, 0);
    check("rst_req", o_req_valid, 0);
    check("rst_wb", o_wb_data, 0);
    check("rst_mis", o_misaligned, 0);
    check("rst_addr", o_req_addr, 0);
    check("rst_wmask", o_req_wmask, 0);
    check("rst_wdata", o_req_wdata, 0);
    @(posedge clk); #1; rst = 1'b0;

    run_op(4'b0001, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0);
    run_op(4'b0111, 64'h2004, 64'h0, 64'h8765_4321_0000_0000, 0, 0);
    run_op(4'b1010, 64'h3006, 64'hABCD, 64'h0, 0, 1);
    run_op(4'b0100, 64'h4008, 64'h0, 64'hFEDC_BA98_7654_3210, 3, 2);
    run_op(4'b0011, 64'h1002, 64'h0, 64'h0, 0, 0);
    run_op(4'b0000, 64'h42, 64'h0, 64'h0, 0, 0);
    run_op(4'b1000, 64'h77, 64'h0, 64'h0, 0, 0);

    // Reset while waiting for the response, then a stale response arrives.
    i_memop = 4'b0100; i_exc_alu_out = 64'h5000;
    @(posedge clk); #1; i_req_ready = 1'b1;
    @(posedge clk); #1; i_req_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_wait", o_stall, 1);
    @(posedge clk); #1; rst = 1'b1; i_memop = 4'd0; i_exc_alu_out = 64'd0;
    @(posedge clk); #1; rst = 1'b0; i_resp_valid = 1'b1; i_resp_rdata = 64'h1234;
    @(negedge clk);
    check("rst_wait_req", o_req_valid, 0);
    check("rst_wait_done", o_done, 0);
    check("rst_wait_stall", o_stall, 0);
    @(posedge clk); #1; i_resp_valid = 1'b0;
    @(negedge clk);
    check("late_resp_done", o_done, 0);
    check("late_resp_stall", o_stall, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      op   = 4'($urandom_range(0, 15));
      addr = {$urandom, $urandom};
      decode(op, nb, st, uns);
      if (nb != 0 && $urandom_range(0, 3) != 0)
        addr = addr & ~(64'(nb) - 64'd1);
      run_op(op, addr, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
